// File: rtl/psum_arb_pkg.sv
// Shared types and the round-robin selection helper for the Psum drain arbiter.
package psum_arb_pkg;

    typedef enum logic {ARB, DRAIN} arb_state_t;

    localparam int unsigned MAX_PE   = 32;
    localparam int unsigned MAX_ID_W = 5;

    // First set bit of req scanning circularly from last+1; returns last when req is empty.
    function automatic int unsigned rr_next(
        input logic [MAX_PE-1:0] req,
        input int unsigned       last,
        input int unsigned       num_pe
    );
        int unsigned pick;
        int unsigned cand;
        logic        found;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_PE; k++) begin
            if (k <= num_pe) begin
                cand = last + k;
                if (cand >= num_pe) begin
                    cand = cand - num_pe;
                end
                if (!found && req[cand[MAX_ID_W-1:0]]) begin
                    pick  = cand;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker over the PE request vector.
module rr_picker
    import psum_arb_pkg::*;
#(
    parameter int unsigned NUM_PE = 4,
    parameter int unsigned ID_W   = 2
)(
    input  logic [NUM_PE-1:0] req,
    input  logic [ID_W-1:0]   last_id,
    output logic              any,
    output logic [ID_W-1:0]   pick_id
);

    logic [MAX_PE-1:0] req_ext;

    always_comb begin
        req_ext = MAX_PE'(req);
        any     = |req;
        pick_id = ID_W'(rr_next(req_ext, 32'(last_id), NUM_PE));
    end

endmodule

// File: rtl/psum_drain_arbiter.sv
// Round-robin drain of per-PE Psum buffers into one registered valid/ready stream,
// popping up to burst_len words per grant and tagging each word with its source PE.
module psum_drain_arbiter
    import psum_arb_pkg::*;
#(
    parameter int unsigned NUM_PE     = 4,
    parameter int unsigned PSUM_WIDTH = 18,
    parameter int unsigned BURST_W    = 4,
    parameter int unsigned ID_W       = $clog2(NUM_PE)
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [BURST_W-1:0]           burst_len,
    input  logic [NUM_PE-1:0]            pe_psum_valid,
    input  logic [NUM_PE*PSUM_WIDTH-1:0] pe_psum_data,
    output logic [NUM_PE-1:0]            pe_ren,
    output logic [PSUM_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ID_W-1:0]              out_pe_id,
    output logic                         out_last,
    output logic                         busy
);

    localparam int unsigned CNT_W = BURST_W + 1;

    arb_state_t            state_q, state_d;
    logic [ID_W-1:0]       grant_id_q, grant_id_d;
    logic [ID_W-1:0]       last_id_q, last_id_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      len_q, len_d;
    logic [PSUM_WIDTH-1:0] out_data_q, out_data_d;
    logic [ID_W-1:0]       out_pe_id_q, out_pe_id_d;
    logic                  out_last_q, out_last_d;
    logic                  out_valid_q, out_valid_d;

    logic [PSUM_WIDTH-1:0] pe_word [NUM_PE];
    logic                  any_req;
    logic [ID_W-1:0]       pick_id;
    logic                  src_valid;
    logic                  at_last;
    logic                  pop;

    rr_picker #(
        .NUM_PE (NUM_PE),
        .ID_W   (ID_W)
    ) u_picker (
        .req     (pe_psum_valid),
        .last_id (last_id_q),
        .any     (any_req),
        .pick_id (pick_id)
    );

    always_comb begin
        for (int i = 0; i < NUM_PE; i++) begin
            pe_word[i] = pe_psum_data[i*PSUM_WIDTH +: PSUM_WIDTH];
        end
    end

    // Pop whenever the granted buffer has data and the output slot is free or being freed.
    always_comb begin
        src_valid = pe_psum_valid[grant_id_q];
        at_last   = (cnt_q == (len_q - CNT_W'(1)));
        pop       = (state_q == DRAIN) && en && src_valid && (!out_valid_q || out_ready);
        pe_ren    = '0;
        if (pop) begin
            pe_ren[grant_id_q] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        last_id_d   = last_id_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        out_data_d  = out_data_q;
        out_pe_id_d = out_pe_id_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            ARB: begin
                if (en && any_req) begin
                    grant_id_d = pick_id;
                    last_id_d  = pick_id;
                    len_d      = (burst_len == '0) ? {1'b1, {BURST_W{1'b0}}} : {1'b0, burst_len};
                    cnt_d      = '0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (!src_valid) begin
                    state_d = ARB;
                end else if (pop) begin
                    out_data_d  = pe_word[grant_id_q];
                    out_pe_id_d = grant_id_q;
                    out_last_d  = at_last;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                    if (at_last) begin
                        state_d = ARB;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ARB;
            grant_id_q  <= '0;
            last_id_q   <= ID_W'(NUM_PE - 1);
            cnt_q       <= '0;
            len_q       <= '0;
            out_data_q  <= '0;
            out_pe_id_q <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            last_id_q   <= last_id_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            out_data_q  <= out_data_d;
            out_pe_id_q <= out_pe_id_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_pe_id = out_pe_id_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != ARB) || out_valid_q;

endmodule
